instruction_fetch: RTL and testbench

Instruction-fetch stage sitting directly upstream of the IF/ID pipeline buffer. Owns the program counter and issues one word read at a time to instruction memory over a valid/ready request and valid response. Delivers {out_pc, out_inst, out_valid} to the IF/ID buffer and honours stall and branch/jump redirect from later stages. At most one request is outstanding, so peak throughput is one instruction per 2 cycles.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/instruction_fetch.sv | 115 +++++++++++
 tb/tb_instruction_fetch.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and defaults, also used by the IF/ID buffer and the decoder.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INST       = 32'h0;
    localparam int unsigned DEF_RESET_PC   = 0;
    localparam int unsigned DEF_PC_INC     = 1;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: owns the PC and keeps one imem read in flight.
// It feeds {out_pc, out_inst, out_valid} to the IF/ID buffer and honours stall and redirect.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter logic [ADDR_W-1:0]  PC_INC   = ADDR_W'(DEF_PC_INC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_stall,
    input  logic              in_redirect,
    input  logic [ADDR_W-1:0] in_target,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_inst,
    output logic              out_valid
);

    localparam logic [DATA_W-1:0] NOP = DATA_W'(NOP_INST);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [DATA_W-1:0] r_hold_inst;
    logic              r_drop;
    logic [ADDR_W-1:0] r_out_pc;
    logic [DATA_W-1:0] r_out_inst;
    logic              r_out_valid;
    logic              w_accept;

    assign imem_req_valid = (r_state == REQ) && !in_redirect;
    assign imem_addr      = r_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    assign out_pc    = r_out_pc;
    assign out_inst  = r_out_inst;
    assign out_valid = r_out_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= REQ;
            r_pc        <= RESET_PC;
            r_fetch_pc  <= '0;
            r_hold_inst <= NOP;
            r_drop      <= 1'b0;
            r_out_pc    <= '0;
            r_out_inst  <= NOP;
            r_out_valid <= 1'b0;
        end else if (in_redirect) begin
            // Redirect squashes the output even under stall; an in-flight read is poisoned.
            r_pc        <= in_target;
            r_out_valid <= 1'b0;
            r_out_inst  <= NOP;
            case (r_state)
                WAIT: begin
                    if (imem_rsp_valid) begin
                        r_drop  <= 1'b0;
                        r_state <= REQ;
                    end else begin
                        r_drop  <= 1'b1;
                    end
                end
                HOLD:    r_state <= REQ;
                default: r_state <= REQ;
            endcase
        end else begin
            if (!in_stall) begin
                r_out_valid <= 1'b0;
                r_out_inst  <= NOP;
            end
            case (r_state)
                REQ: begin
                    if (w_accept) begin
                        r_fetch_pc <= r_pc;
                        r_pc       <= r_pc + PC_INC;
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= REQ;
                        end else if (in_stall) begin
                            r_hold_inst <= imem_rsp_data;
                            r_state     <= HOLD;
                        end else begin
                            r_out_pc    <= r_fetch_pc;
                            r_out_inst  <= imem_rsp_data;
                            r_out_valid <= 1'b1;
                            r_state     <= REQ;
                        end
                    end
                end
                HOLD: begin
                    if (!in_stall) begin
                        r_out_pc    <= r_fetch_pc;
                        r_out_inst  <= r_hold_inst;
                        r_out_valid <= 1'b1;
                        r_state     <= REQ;
                    end
                end
                default: r_state <= REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; memory model returns addr+0x100 after a settable latency.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        in_stall;
    logic        in_redirect;
    logic [31:0] in_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_valid;

    int          n_chk;
    int          n_fail;
    int          lat;
    logic        pv [4];
    logic [31:0] pd [4];

    instruction_fetch #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_stall       (in_stall),
        .in_redirect    (in_redirect),
        .in_target      (in_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_valid      (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] pc,
                              input logic [31:0] inst);
        check({tag, ".valid"}, {31'b0, out_valid}, {31'b0, v});
        check({tag, ".pc"},    out_pc,   pc);
        check({tag, ".inst"},  out_inst, inst);
    endtask

    // One clock: sample the handshake just before the edge, then advance the memory model.
    task automatic cyc();
        logic        acc;
        logic [31:0] a;
        #2;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_addr;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            pv[i] = pv[i+1];
            pd[i] = pd[i+1];
        end
        pv[3] = 1'b0;
        pd[3] = 32'h0;
        if (acc === 1'b1) begin
            pv[lat-1] = 1'b1;
            pd[lat-1] = a + 32'h100;
        end
        imem_rsp_valid = pv[0];
        imem_rsp_data  = pv[0] ? pd[0] : 32'hDEAD_BEEF;
    endtask

    initial begin
        clk = 0; rst_n = 0; in_stall = 0; in_redirect = 0; in_target = 0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
        n_chk = 0; n_fail = 0; lat = 1;
        for (int i = 0; i < 4; i++) begin pv[i] = 1'b0; pd[i] = 32'h0; end

        cyc(); cyc();
        rst_n = 1;
        expect_out("reset", 1'b0, 32'h0, 32'h0);
        check("reset.rv", {31'b0, imem_req_valid}, 32'h1);
        check("reset.addr", imem_addr, 32'h0);

        // Memory not ready: request stays posted at addr 0.
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("nordy.rv", {31'b0, imem_req_valid}, 32'h1);
            check("nordy.addr", imem_addr, 32'h0);
            check("nordy.valid", {31'b0, out_valid}, 32'h0);
        end
        imem_req_ready = 1;

        // Streaming: one instruction every two cycles with bubbles.
        cyc();
        check("acc0.rv", {31'b0, imem_req_valid}, 32'h0);
        check("acc0.addr", imem_addr, 32'h1);
        cyc();  expect_out("d0", 1'b1, 32'h0, 32'h100);
        cyc();  expect_out("bub0", 1'b0, 32'h0, 32'h0);
        cyc();  expect_out("d1", 1'b1, 32'h1, 32'h101);

        // Stall across the response for pc=2.
        in_stall = 1;
        cyc();
        expect_out("stl0", 1'b1, 32'h1, 32'h101);
        check("stl0.addr", imem_addr, 32'h3);
        for (int i = 0; i < 3; i++) begin
            cyc();
            expect_out("stl", 1'b1, 32'h1, 32'h101);
            check("stl.rv", {31'b0, imem_req_valid}, 32'h0);
        end
        in_stall = 0;
        cyc();  expect_out("rel", 1'b1, 32'h2, 32'h102);
        check("rel.addr", imem_addr, 32'h3);

        cyc(); cyc();  expect_out("d3", 1'b1, 32'h3, 32'h103);
        cyc(); cyc();  expect_out("d4", 1'b1, 32'h4, 32'h104);

        // Redirect while waiting on pc=5 (2-cycle memory).
        lat = 2;
        cyc();  expect_out("w5", 1'b0, 32'h4, 32'h0);
        in_redirect = 1; in_target = 32'h40;
        cyc();
        expect_out("rdw", 1'b0, 32'h4, 32'h0);
        check("rdw.addr", imem_addr, 32'h40);
        in_redirect = 0; lat = 1;
        cyc();
        expect_out("drop", 1'b0, 32'h4, 32'h0);
        check("drop.rv", {31'b0, imem_req_valid}, 32'h1);
        check("drop.addr", imem_addr, 32'h40);
        cyc(); cyc();  expect_out("d40", 1'b1, 32'h40, 32'h140);

        // Redirect coincident with the response.
        cyc();
        in_redirect = 1; in_target = 32'h80;
        cyc();
        expect_out("rdrsp", 1'b0, 32'h40, 32'h0);
        check("rdrsp.addr", imem_addr, 32'h80);
        in_redirect = 0;
        cyc();  check("rdrsp.acc", imem_addr, 32'h81);
        cyc();  expect_out("d80", 1'b1, 32'h80, 32'h180);

        // Redirect while stalled in HOLD.
        in_stall = 1;
        cyc();  expect_out("hstl0", 1'b1, 32'h80, 32'h180);
        cyc();  expect_out("hstl1", 1'b1, 32'h80, 32'h180);
        check("hold.rv", {31'b0, imem_req_valid}, 32'h0);
        in_redirect = 1; in_target = 32'h20;
        cyc();
        expect_out("rdhold", 1'b0, 32'h80, 32'h0);
        check("rdhold.addr", imem_addr, 32'h20);
        in_redirect = 0; in_stall = 0;
        cyc();  check("rdhold.acc", imem_addr, 32'h21);
        cyc();  expect_out("d20", 1'b1, 32'h20, 32'h120);

        // Reset during WAIT; the stale response lands while in REQ.
        lat = 2;
        cyc();
        rst_n = 0;
        cyc();
        expect_out("rst2", 1'b0, 32'h0, 32'h0);
        check("rst2.addr", imem_addr, 32'h0);
        rst_n = 1; imem_req_ready = 0;
        cyc();
        expect_out("stale", 1'b0, 32'h0, 32'h0);
        check("stale.rv", {31'b0, imem_req_valid}, 32'h1);
        imem_req_ready = 1; lat = 1;
        cyc(); cyc();  expect_out("rst2d0", 1'b1, 32'h0, 32'h100);

        // PC wrap at the top of the address space.
        in_redirect = 1; in_target = 32'hFFFF_FFFF;
        cyc();
        expect_out("rdreq", 1'b0, 32'h0, 32'h0);
        check("rdreq.addr", imem_addr, 32'hFFFF_FFFF);
        in_redirect = 0;
        cyc();  check("wrap.addr", imem_addr, 32'h0);
        cyc();  expect_out("dwrap", 1'b1, 32'hFFFF_FFFF, 32'h0000_00FF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
